// File: rtl/dpram_arb_pkg.sv
// Shared types and defaults for the dual-port RAM port arbiter.
package dpram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int DEF_ADDR_W = 6;
   localparam int DEF_DATA_W = 8;

   // Width of a requester index; never below one bit.
   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection: round-robin when DPRAM_ARB_RR_EN is defined,
// otherwise fixed priority (lowest index wins).
module rr_arbiter
   import dpram_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last_grant,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_grant_idx
);

   logic [NUM_REQ-1:0] w_cand;

`ifdef DPRAM_ARB_RR_EN
   logic [NUM_REQ-1:0] w_above;

   // Requests strictly after the last winner take precedence; if none, wrap around.
   always_comb begin
      w_above = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_above[i] = i_req[i] && (i > int'(i_last_grant));
      end
   end

   assign w_cand = (|w_above) ? w_above : i_req;
`else
   logic w_unused_last_grant;

   assign w_unused_last_grant = ^i_last_grant;
   assign w_cand              = i_req;
`endif

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_cand[i]) begin
            o_grant     = NUM_REQ'(1) << i;
            o_grant_idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Serialises NUM_REQ requesters onto one RAM port; arbitration policy is
// selected by DPRAM_ARB_RR_EN (round-robin) or its absence (fixed priority).
module dpram_port_arbiter
   import dpram_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      mem_valid,
   input  logic                      mem_ready,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_data,
   input  logic [DATA_W-1:0]         mem_q
);

   localparam int IDX_W = idx_width(NUM_REQ);

   state_t               r_state;
   logic [IDX_W-1:0]     r_last_grant;
   logic [IDX_W-1:0]     r_gnt_idx;
   logic                 r_mem_valid;
   logic                 r_mem_we;
   logic [ADDR_W-1:0]    r_mem_addr;
   logic [DATA_W-1:0]    r_mem_data;
   logic [DATA_W-1:0]    r_rsp_data;
   logic [NUM_REQ-1:0]   r_rsp_valid;

   logic [NUM_REQ-1:0]   w_grant;
   logic [IDX_W-1:0]     w_grant_idx;
   logic                 w_accept;
   logic                 w_sel_we;
   logic [ADDR_W-1:0]    w_sel_addr;
   logic [DATA_W-1:0]    w_sel_data;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .i_req        (req_valid),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant),
      .o_grant_idx  (w_grant_idx)
   );

   // Gated by rst_n so no requester sees an accept while reset is held.
   assign w_accept  = rst_n && (r_state == IDLE) && (|req_valid);
   assign req_ready = w_accept ? w_grant : '0;

   always_comb begin
      w_sel_we   = 1'b0;
      w_sel_addr = '0;
      w_sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_sel_we   = req_we[i];
            w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            w_sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_last_grant <= IDX_W'(NUM_REQ - 1);
         r_gnt_idx    <= '0;
         r_mem_valid  <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_data   <= '0;
         r_rsp_data   <= '0;
         r_rsp_valid  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_mem_we     <= w_sel_we;
                  r_mem_addr   <= w_sel_addr;
                  r_mem_data   <= w_sel_data;
                  r_gnt_idx    <= w_grant_idx;
                  r_last_grant <= w_grant_idx;
                  r_mem_valid  <= 1'b1;
                  r_state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (mem_ready) begin
                  r_mem_valid <= 1'b0;
                  r_state     <= WAIT;
               end
            end
            WAIT: begin
               // q was updated by the RAM at the handshake edge; it is valid now.
               r_rsp_data  <= mem_q;
               r_rsp_valid <= NUM_REQ'(1) << r_gnt_idx;
               r_state     <= RESP;
            end
            RESP: begin
               r_rsp_valid <= '0;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign mem_valid = r_mem_valid;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_data  = r_mem_data;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level model of the arbiter and a behavioural RAM stub.
`timescale 1ns/1ps
module tb_dpram_port_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 6;
   localparam int DATA_W  = 8;

   logic                      clk   = 1'b0;
   logic                      rst_n = 1'b1;
   logic [NUM_REQ-1:0]        req_valid = '0;
   logic [NUM_REQ-1:0]        req_we    = '0;
   logic [NUM_REQ*ADDR_W-1:0] req_addr  = '0;
   logic [NUM_REQ*DATA_W-1:0] req_data  = '0;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data;
   logic                      mem_valid;
   logic                      mem_ready = 1'b1;
   logic                      mem_we;
   logic [ADDR_W-1:0]         mem_addr;
   logic [DATA_W-1:0]         mem_data;
   logic [DATA_W-1:0]         mem_q = '0;

   always #5 clk = ~clk;

   dpram_port_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_q     (mem_q)
   );

   // RAM port stub: q updates at the handshake edge, writes echo their data.
   logic [DATA_W-1:0] ram [64];
   always @(posedge clk) begin
      if (mem_valid && mem_ready) begin
         if (mem_we) begin
            ram[mem_addr] <= mem_data;
            mem_q         <= mem_data;
         end else begin
            mem_q <= ram[mem_addr];
         end
      end
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Requester-side stimulus
   bit [NUM_REQ-1:0] p_valid = '0;
   bit               p_we   [NUM_REQ];
   logic [5:0]       p_addr [NUM_REQ];
   logic [7:0]       p_data [NUM_REQ];
   bit               refill_all  = 1'b0;
   bit               refill_rand = 1'b0;
   int               bp_left     = 0;

   // Transaction-level model
   logic [7:0]       ref_mem [64];
   bit               in_reset = 1'b0;
   bit               busy     = 1'b0;
   bit               issuing  = 1'b0;
   int               post     = 0;
   int               m_last   = NUM_REQ - 1;
   int               m_g      = 0;
   bit               m_we;
   logic [5:0]       m_addr;
   logic [7:0]       m_data;
   logic [7:0]       m_exp;
   int               exp_win  = -1;

   // Observations for directed checks
   logic [NUM_REQ-1:0] obs_ready;
   int                 obs_acc_cyc = 0;
   int                 obs_lat     = -1;
   logic [7:0]         obs_rsp_data;
   logic [NUM_REQ-1:0] obs_rsp_vec;
   int                 mv_cycles = 0;
   int                 grant_log [$];
   int                 exp_order [5];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int pick(input bit [NUM_REQ-1:0] pend);
`ifdef DPRAM_ARB_RR_EN
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (pend[(m_last + k) % NUM_REQ]) return (m_last + k) % NUM_REQ;
      end
`else
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pend[i]) return i;
      end
`endif
      return -1;
   endfunction

   function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic new_req(input int i, input bit we, input logic [5:0] a, input logic [7:0] d);
      p_valid[i] = 1'b1;
      p_we[i]    = we;
      p_addr[i]  = a;
      p_data[i]  = d;
   endtask

   task automatic pack();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i]                     = p_valid[i];
         req_we[i]                        = p_we[i];
         req_addr[i*ADDR_W +: ADDR_W]     = p_addr[i];
         req_data[i*DATA_W +: DATA_W]     = p_data[i];
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!p_valid[i] && (refill_all || (refill_rand && $urandom_range(0, 3) == 0))) begin
            new_req(i, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? 6'h3F : 6'($urandom_range(0, 7)),
                    8'($urandom_range(0, 255)));
         end
      end
      if (issuing && bp_left > 0) begin
         mem_ready = 1'b0;
         bp_left--;
      end else if (refill_rand) begin
         mem_ready = ($urandom_range(0, 3) != 0);
      end else begin
         mem_ready = 1'b1;
      end
      pack();
   endtask

   task automatic compare();
      logic [NUM_REQ-1:0] exp_ready;
      exp_win   = (in_reset || busy) ? -1 : pick(p_valid);
      exp_ready = (exp_win >= 0) ? NUM_REQ'(1) << exp_win : '0;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("mem_valid", 32'(mem_valid), 32'(issuing));
      if (issuing) begin
         check("mem_we",   32'(mem_we),   32'(m_we));
         check("mem_addr", 32'(mem_addr), 32'(m_addr));
         check("mem_data", 32'(mem_data), 32'(m_data));
      end
      check("rsp_valid", 32'(rsp_valid), (post == 2) ? 32'(NUM_REQ'(1) << m_g) : 32'd0);
      if (post == 2) check("rsp_data", 32'(rsp_data), 32'(m_exp));
      obs_ready = req_ready;
      if (|req_ready) begin
         obs_acc_cyc = cyc;
         grant_log.push_back(onehot_idx(req_ready));
      end
      if (mem_valid) mv_cycles++;
      if (|rsp_valid) begin
         obs_lat      = cyc - obs_acc_cyc;
         obs_rsp_data = rsp_data;
         obs_rsp_vec  = rsp_valid;
      end
   endtask

   task automatic model_edge();
      if (in_reset) return;
      if (exp_win >= 0) begin
         m_g    = exp_win;
         m_we   = p_we[m_g];
         m_addr = p_addr[m_g];
         m_data = p_data[m_g];
         if (m_we) begin
            ref_mem[m_addr] = m_data;
            m_exp           = m_data;
         end else begin
            m_exp = ref_mem[m_addr];
         end
         m_last  = m_g;
         busy    = 1'b1;
         issuing = 1'b1;
      end else if (issuing) begin
         if (mem_ready) begin
            issuing = 1'b0;
            post    = 1;
         end
      end else if (post == 1) begin
         post = 2;
      end else if (post == 2) begin
         post = 0;
         busy = 1'b0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (obs_ready[i]) p_valid[i] = 1'b0;
      end
   endtask

   task automatic run_cycle();
      drive();
      @(negedge clk);
      compare();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
   endtask

   task automatic run_until_idle(input int budget);
      int n = 0;
      while ((busy || (|p_valid)) && n < budget) begin
         run_cycle();
         n++;
      end
      if (busy || (|p_valid)) check("idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic reset_model();
      in_reset = 1'b1;
      busy     = 1'b0;
      issuing  = 1'b0;
      post     = 0;
      m_last   = NUM_REQ - 1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
      check({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
      check({tag, "_mem_we"},    32'(mem_we),    32'd0);
      check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
      check({tag, "_mem_data"},  32'(mem_data),  32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) begin
         ram[i]     = '0;
         ref_mem[i] = '0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         p_we[i]   = 1'b0;
         p_addr[i] = '0;
         p_data[i] = '0;
      end
`ifdef DPRAM_ARB_RR_EN
      exp_order = '{0, 1, 2, 3, 0};
`else
      exp_order = '{0, 0, 0, 0, 0};
`endif

      // Reset state
      reset_model();
      #1 rst_n = 1'b0;
      run_cycle();
      run_cycle();
      check_reset_outputs("reset");
      rst_n    = 1'b1;
      in_reset = 1'b0;

      // Single write
      new_req(0, 1'b1, 6'h05, 8'hA5);
      mv_cycles = 0;
      obs_lat   = -1;
      run_until_idle(30);
      check("wr_latency",   32'(obs_lat),      32'd3);
      check("wr_rsp_data",  32'(obs_rsp_data), 32'hA5);
      check("wr_rsp_vec",   32'(obs_rsp_vec),  32'b0001);
      check("wr_mv_cycles", 32'(mv_cycles),    32'd1);

      // Read-back from a different requester
      new_req(1, 1'b0, 6'h05, 8'h00);
      obs_lat = -1;
      run_until_idle(30);
      check("rd_latency",  32'(obs_lat),      32'd3);
      check("rd_rsp_data", 32'(obs_rsp_data), 32'hA5);
      check("rd_rsp_vec",  32'(obs_rsp_vec),  32'b0010);

      // Leave requester 3 as the last winner before contention
      new_req(3, 1'b0, 6'h05, 8'h00);
      run_until_idle(30);

      // Contention: all four held high continuously
      grant_log.delete();
      refill_all = 1'b1;
      for (int n = 0; n < 60 && grant_log.size() < 5; n++) run_cycle();
      refill_all = 1'b0;
      check("contention_count", 32'(grant_log.size() >= 5), 32'd1);
      for (int k = 0; k < 5 && k < grant_log.size(); k++) begin
         check("contention_grant", 32'(grant_log[k]), 32'(exp_order[k]));
      end
      run_until_idle(200);

      // Backpressure: three stalled ISSUE cycles
      bp_left = 3;
      obs_lat = -1;
      new_req(2, 1'b1, 6'h20, 8'h5A);
      run_until_idle(40);
      check("bp_latency",  32'(obs_lat),      32'd6);
      check("bp_rsp_data", 32'(obs_rsp_data), 32'h5A);

      // Boundary address
      new_req(3, 1'b1, 6'h3F, 8'hFF);
      run_until_idle(30);
      obs_rsp_data = '0;
      new_req(2, 1'b0, 6'h3F, 8'h00);
      run_until_idle(30);
      check("bnd_rsp_data", 32'(obs_rsp_data), 32'hFF);
      check("bnd_rsp_vec",  32'(obs_rsp_vec),  32'b0100);

      // Reset while the RAM result is in flight
      new_req(1, 1'b1, 6'h10, 8'h3C);
      for (int n = 0; n < 20 && post != 1; n++) run_cycle();
      check("reach_wait", 32'(post), 32'd1);
      new_req(2, 1'b0, 6'h10, 8'h00);
      new_req(0, 1'b0, 6'h3F, 8'h00);
      pack();
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("midop");
      reset_model();
      @(posedge clk);
      #1;
      cyc++;
      run_cycle();
      run_cycle();
      grant_log.delete();
      rst_n    = 1'b1;
      in_reset = 1'b0;
      run_until_idle(60);
      check("post_rst_grants", 32'(grant_log.size()), 32'd2);
      if (grant_log.size() > 0) check("post_rst_first", 32'(grant_log[0]), 32'd0);

      // Random traffic with random RAM backpressure
      refill_rand = 1'b1;
      for (int n = 0; n < 1500; n++) run_cycle();
      refill_rand = 1'b0;
      run_until_idle(300);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dpram_port_arbiter.md
# dpram_port_arbiter

Shares one port of the 64x8 dual-port RAM between NUM_REQ independent requesters. Each requester issues single read or write transactions over a valid/ready handshake. The arbiter serialises them onto the RAM port's valid/ready interface and returns the RAM's q output to the granted requester as a one-cycle response pulse. One instance sits in front of each RAM port that needs sharing.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_W, 6: RAM address width.
- DATA_W, 8: RAM data width.

Ports (clock and reset first):
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_we  in  NUM_REQ  per-requester write enable (1 = write, 0 = read).
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  packed write data; same packing.
- req_ready  out  NUM_REQ  one-hot; accept strobe to the winning requester.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse.
- rsp_data  out  DATA_W  response data: read data, or the written data echoed by the RAM.
- mem_valid  out  1  to the RAM port's valid.
- mem_ready  in  1  from the RAM port's ready.
- mem_we, mem_addr, mem_data  out  1/ADDR_W/DATA_W  to the RAM port.
- mem_q  in  DATA_W  from the RAM port's q.

## Operation
The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any req_valid is high, the arbiter picks a winner g and drives req_ready[g]=1 combinationally in the same cycle.
  - On that edge it latches req_we/addr/data[g] and g, updates the pointer, and moves to ISSUE.
  - If no req_valid is high, req_ready stays 0.
- **ISSUE**
  - mem_valid=1 with the latched fields, held stable.
  - When mem_ready=1 at the edge, the RAM transaction completes and the FSM moves to WAIT. Otherwise it stays in ISSUE.
- **WAIT**
  - mem_valid=0.
  - rsp_data is captured from mem_q at the end of this cycle, because the RAM updates q at the handshake edge.
  - The FSM then moves to RESP.
- **RESP**
  - rsp_valid[g]=1 for exactly one cycle. There is no response backpressure.
  - The FSM then moves to IDLE.
- Arbitration is round-robin. The search starts at last_grant+1 modulo NUM_REQ. last_grant resets to NUM_REQ-1, so requester 0 wins first.
- Requests are never accepted outside IDLE. A requester must hold req_valid and its fields until it sees req_ready.
- req_valid must not depend combinationally on req_ready.

## Timing
- Reset values: state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, mem_valid=0, mem_we=0, mem_addr=0, mem_data=0, last_grant=NUM_REQ-1.
- With mem_ready=1, the arbiter accepts at edge T0, completes the RAM handshake at T1, captures at T2, and asserts rsp_valid in the cycle after T2. It returns to IDLE at T3.
- Maximum throughput is one transaction per 4 cycles. Each cycle mem_ready is low adds one cycle.
- Simultaneous requests: exactly one grant per IDLE cycle. The losers keep waiting.
- Address 0x3F is valid, and the address is passed through without wrap logic.
- Reset asserted mid-operation: all outputs go to reset values immediately (mem_valid drops asynchronously). The in-flight transaction is dropped with no response.

## Configuration
- DPRAM_ARB_RR_EN defined: round-robin arbitration as described above.
- DPRAM_ARB_RR_EN undefined: fixed priority, where the lowest asserted index wins. last_grant is still tracked but ignored.

## Structure
- Package dpram_arb_pkg holds:
  - the FSM state enum (IDLE, ISSUE, WAIT, RESP);
  - the defaults ADDR_W=6 and DATA_W=8;
  - a clog2-based grant-index width function.
- Sub-module rr_arbiter is purely combinational. Its inputs are the request vector and the last_grant pointer. Its outputs are the one-hot grant and the grant index. It contains the DPRAM_ARB_RR_EN switch.

## Test plan
- **Single write:** req_valid[0], we=1, addr=0x05, data=0xA5. Expect mem_valid for one cycle with addr 0x05, data 0xA5, we 1. Expect rsp_valid[0] with rsp_data=0xA5 three cycles after accept.
- **Read-back:** req_valid[1], we=0, addr=0x05. Expect rsp_valid[1] with rsp_data=0xA5. No other rsp_valid bit toggles.
- **Contention:** all four req_valid held high continuously. With DPRAM_ARB_RR_EN, grants go in the order 0,1,2,3,0. Without it, grants go 0,0,0.
- **Backpressure:** force mem_ready=0 for 3 cycles during ISSUE. Expect mem_addr/data/we held stable and the response delayed by exactly 3 cycles.
- **Reset mid-op:** drop rst_n during WAIT. Expect all outputs 0 immediately and no rsp_valid. After release, with req 2 and req 0 both valid, req 0 is granted first.
- **Boundary address:** write 0xFF to 0x3F from req 3, then read it from req 2. Expect rsp_data=0xFF.
